bitstream_serializer: RTL and testbench
=======================================

BITSTREAM_SERIALIZER -- requirements
Module: bitstream_serializer

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 8: width of the input word; legal values are 2..32.
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 emits bit IN_WIDTH-1 first, 0 emits bit 0 first.
REQ-003 SHALL have parameter CNT_WIDTH, default 16: width of the frame bit counter.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have ports s_tvalid in 1, s_tready out 1, s_tdata in IN_WIDTH, s_tlast in 1: word-wide AXI-stream slave.
REQ-007 SHALL have ports m_tvalid out 1, m_tready in 1, m_tdata out 1, m_tlast out 1: 1-bit AXI-stream master, which feeds the FPGA configuration bitstream input.
REQ-008 SHALL have port frame_bits, output, CNT_WIDTH: the number of bits accepted downstream in the current or last frame.
REQ-009 SHALL have port frame_done, output, 1 bit: a single-cycle pulse after the last bit of a frame is accepted.

Function
REQ-010 SHALL implement FSM states IDLE (shift register empty) and SHIFT (holding a word, bit index 0..IN_WIDTH-1).
REQ-011 In IDLE, SHALL drive s_tready=1 and m_tvalid=0.
REQ-012 On an IDLE s_tvalid&&s_tready, SHALL load s_tdata and s_tlast, set index 0, and enter SHIFT; latency from input handshake to the first m_tvalid SHALL be 1 cycle.
REQ-013 In SHIFT, SHALL drive m_tvalid=1 and m_tdata = the current bit in MSB_FIRST order.
REQ-014 m_tlast SHALL be 1 only on the final bit (index IN_WIDTH-1) of a word loaded with tlast=1.
REQ-015 On m_tvalid&&m_tready with index < IN_WIDTH-1, SHALL increment the index.
REQ-016 On m_tvalid&&m_tready at index IN_WIDTH-1, SHALL drive s_tready=1 in the same cycle.
  - If s_tvalid=1 in that cycle: SHALL load the new word and stay in SHIFT with no bubble.
  - Otherwise: SHALL return to IDLE.
REQ-017 In SHIFT, s_tready SHALL be 0 except in the case of REQ-016.
REQ-018 While m_tvalid=1 and m_tready=0, m_tdata and m_tlast SHALL hold stable and the index SHALL not change.
REQ-019 frame_bits SHALL increment on each m_tvalid&&m_tready and saturate at all-ones.
REQ-020 On the first handshake of a new frame, frame_bits SHALL load 1; a new frame is the first handshake after frame_done or after reset.
REQ-021 frame_done SHALL pulse for 1 cycle on the cycle after the m_tlast handshake; frame_bits then holds its value until the next frame starts.
REQ-022 s_tlast on a word SHALL affect only that word's final bit; s_tlast is ignored when s_tvalid=0.

Reset
REQ-023 While rst=1, the FSM SHALL be in IDLE, with m_tvalid=0, m_tdata=0, m_tlast=0, frame_bits=0, frame_done=0, s_tready=0.
REQ-024 s_tready SHALL rise to 1 on the first clock edge after rst deasserts.
REQ-025 Reset mid-word SHALL discard the partial word with no further m_tvalid; the next accepted word starts a new frame.

Structure
REQ-026 SHALL place the FSM state enum (IDLE, SHIFT) in the shared tiny_fpga package, alongside the bitstream width constants.
REQ-027 SHALL use the shared axi_stream_if (slave modport on the input side, master modport on the output side) at integration level; the module ports remain flat.
REQ-028 SHALL be a single module with no sub-modules; the bit-select mux and counters are inline.

Verification
REQ-029 Bench SHALL check: IN_WIDTH=8, MSB_FIRST=1, word 0xA5 with tlast, m_tready=1 -> m_tdata 1,0,1,0,0,1,0,1; m_tlast only on the 8th bit; frame_done 1 cycle later; frame_bits=8.
REQ-030 Bench SHALL check: MSB_FIRST=0, words 0x01 then 0x80 (tlast), s_tvalid held high, m_tready=1 -> 16 contiguous valid cycles with no bubble; bits 1,0x7 then 0x7,1; frame_bits=16.
REQ-031 Bench SHALL check: random m_tready backpressure at 50% -> m_tdata and m_tlast stable while stalled; no bit lost or duplicated over 100 random words.
REQ-032 Bench SHALL check: rst asserted after 3 bits of 0xFF -> m_tvalid=0 immediately; after release, word 0x00 with tlast yields exactly 8 zeros and frame_bits=8.
REQ-033 Bench SHALL check: CNT_WIDTH=4 with a 3-word (24-bit) frame -> frame_bits saturates at 15 and frame_done still pulses once.
REQ-034 Bench SHALL check: s_tvalid asserted while mid-word at index 3 -> s_tready=0 until the index-7 handshake, and the word is accepted in that cycle.

Source files
------------

// File: rtl/tiny_fpga_pkg.sv
// tiny_fpga_pkg: shared types and bitstream width constants for the tiny FPGA configuration path
package tiny_fpga_pkg;
  typedef enum logic {IDLE, SHIFT} ser_state_t;
  localparam int CFG_WORD_WIDTH = 8;
  localparam int CFG_CNT_WIDTH = 16;
endpackage

// File: rtl/axi_stream_if.sv
// axi_stream_if: shared AXI-stream bundle used to wire flat-port blocks together at integration level
interface axi_stream_if #(parameter int W = 8);
  logic tvalid;
  logic tready;
  logic tlast;
  logic [W-1:0] tdata;
  modport master(output tvalid, tdata, tlast, input tready);
  modport slave(input tvalid, tdata, tlast, output tready);
endinterface

// File: rtl/bitstream_serializer.sv
// bitstream_serializer: turns word-wide AXI-stream input into the 1-bit configuration bitstream with frame bit counting
module bitstream_serializer
  import tiny_fpga_pkg::*;
#(
  parameter int IN_WIDTH  = CFG_WORD_WIDTH,
  parameter int MSB_FIRST = 1,
  parameter int CNT_WIDTH = CFG_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  input  logic [IN_WIDTH-1:0]  s_tdata,
  input  logic                 s_tlast,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic                 m_tdata,
  output logic                 m_tlast,
  output logic [CNT_WIDTH-1:0] frame_bits,
  output logic                 frame_done
);
  localparam int IW = $clog2(IN_WIDTH);
  localparam logic [IW-1:0] LAST = IW'(IN_WIDTH - 1);
  ser_state_t state, state_n;
  logic [IN_WIDTH-1:0] sreg;
  logic [IW-1:0] idx;
  logic word_last, rdy, new_frame, m_hs, fin, load;
  // the word is shifted so the outgoing bit always sits at one fixed end
  assign m_tvalid = state == SHIFT;
  assign m_tdata  = m_tvalid && (MSB_FIRST != 0 ? sreg[IN_WIDTH-1] : sreg[0]);
  assign m_tlast  = m_tvalid && word_last && idx == LAST;
  assign m_hs     = m_tvalid && m_tready;
  assign fin      = m_hs && idx == LAST;
  // rdy keeps s_tready low through reset and until the first edge after release
  assign s_tready = rdy && (state == IDLE || fin);
  assign load     = s_tvalid && s_tready;
  always_comb begin
    state_n = load ? SHIFT : fin ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg       <= '0;
      idx        <= '0;
      word_last  <= 1'b0;
      rdy        <= 1'b0;
      new_frame  <= 1'b1;
      frame_bits <= '0;
      frame_done <= 1'b0;
    end else begin
      rdy        <= 1'b1;
      frame_done <= m_hs && m_tlast;
      if (load) begin
        sreg      <= s_tdata;
        word_last <= s_tlast;
        idx       <= '0;
      end else if (m_hs) begin
        sreg <= MSB_FIRST != 0 ? sreg << 1 : sreg >> 1;
        idx  <= idx + 1'b1;
      end
      if (m_hs) begin
        frame_bits <= new_frame ? CNT_WIDTH'(1) : frame_bits + CNT_WIDTH'(!(&frame_bits));
        new_frame  <= m_tlast;
      end
    end
  end
endmodule

// File: tb/tb_bitstream_serializer.sv
// tb_bitstream_serializer: table, directed and randomized checks of three serializer configurations against a queue model
module tb_bitstream_serializer;
  logic clk = 1'b0;
  logic rst;
  logic s_tvalid, s_tlast;
  logic [7:0] s_tdata;
  logic m_tready = 1'b1;
  logic rnd = 1'b0;
  logic s_tready_a, m_tvalid_a, m_tdata_a, m_tlast_a, frame_done_a;
  logic s_tready_b, m_tvalid_b, m_tdata_b, m_tlast_b, frame_done_b;
  logic s_tready_c, m_tvalid_c, m_tdata_c, m_tlast_c, frame_done_c;
  logic [15:0] frame_bits_a, frame_bits_b;
  logic [3:0] frame_bits_c;
  int n_total = 0, n_pass = 0;
  bit q_a[$], q_b[$], q_l[$], hist_a[$], hist_b[$];
  int cnt, hs_count = 0, run = 0, max_run = 0, done_a_cnt = 0, done_c_cnt = 0;
  bit newf, done_exp, stall, rdy_ok;
  logic [1:0] prev;
  typedef struct {
    logic [7:0] data;
    logic       last;
    logic [7:0] seq_a;
    logic [7:0] seq_b;
  } vec_t;
  vec_t tbl[3];

  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1 m_tready = rnd ? 1'($urandom_range(1)) : 1'b1;
  end

  bitstream_serializer #(.IN_WIDTH(8), .MSB_FIRST(1), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .rst(rst), .s_tvalid(s_tvalid), .s_tready(s_tready_a), .s_tdata(s_tdata), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid_a), .m_tready(m_tready), .m_tdata(m_tdata_a), .m_tlast(m_tlast_a),
    .frame_bits(frame_bits_a), .frame_done(frame_done_a));
  bitstream_serializer #(.IN_WIDTH(8), .MSB_FIRST(0), .CNT_WIDTH(16)) dut_b (
    .clk(clk), .rst(rst), .s_tvalid(s_tvalid), .s_tready(s_tready_b), .s_tdata(s_tdata), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid_b), .m_tready(m_tready), .m_tdata(m_tdata_b), .m_tlast(m_tlast_b),
    .frame_bits(frame_bits_b), .frame_done(frame_done_b));
  bitstream_serializer #(.IN_WIDTH(8), .MSB_FIRST(1), .CNT_WIDTH(4)) dut_c (
    .clk(clk), .rst(rst), .s_tvalid(s_tvalid), .s_tready(s_tready_c), .s_tdata(s_tdata), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid_c), .m_tready(m_tready), .m_tdata(m_tdata_c), .m_tlast(m_tlast_c),
    .frame_bits(frame_bits_c), .frame_done(frame_done_c));

  task automatic chk(input string n, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
  endtask

  task automatic timeout(input string n);
    n_total++;
    $display("FAIL %s: timed out at %0t", n, $time);
  endtask

  // model: every accepted word becomes a queue of bits; valid means bits pending
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_outs_a", {m_tvalid_a, m_tdata_a, m_tlast_a, frame_done_a, s_tready_a, frame_bits_a}, 0);
      chk("rst_outs_b", {m_tvalid_b, m_tdata_b, m_tlast_b, frame_done_b, s_tready_b, frame_bits_b}, 0);
      chk("rst_outs_c", {m_tvalid_c, m_tdata_c, m_tlast_c, frame_done_c, s_tready_c, frame_bits_c}, 0);
      q_a.delete(); q_b.delete(); q_l.delete();
      cnt = 0; newf = 1; done_exp = 0; stall = 0; rdy_ok = 0; run = 0;
    end else begin
      bit ev, esr, lst;
      ev  = q_a.size() != 0;
      esr = rdy_ok && (q_a.size() == 0 || (q_a.size() == 1 && m_tready));
      chk("frame_bits_a", frame_bits_a, cnt);
      chk("frame_bits_b", frame_bits_b, cnt);
      chk("frame_bits_c", frame_bits_c, cnt > 15 ? 15 : cnt);
      chk("frame_done", {frame_done_a, frame_done_b, frame_done_c}, done_exp ? 7 : 0);
      chk("m_tvalid", {m_tvalid_a, m_tvalid_b, m_tvalid_c}, ev ? 7 : 0);
      chk("s_tready", {s_tready_a, s_tready_b, s_tready_c}, esr ? 7 : 0);
      if (ev) begin
        chk("m_tdata_a", m_tdata_a, q_a[0]);
        chk("m_tdata_b", m_tdata_b, q_b[0]);
        chk("m_tdata_c", m_tdata_c, q_a[0]);
        chk("m_tlast", {m_tlast_a, m_tlast_b, m_tlast_c}, q_l[0] ? 7 : 0);
      end
      if (stall) chk("stall_hold", {m_tdata_a, m_tlast_a}, prev);
      done_a_cnt += frame_done_a;
      done_c_cnt += frame_done_c;
      done_exp = 0;
      if (ev && m_tready) begin
        hist_a.push_back(m_tdata_a);
        hist_b.push_back(m_tdata_b);
        lst = q_l[0];
        void'(q_a.pop_front()); void'(q_b.pop_front()); void'(q_l.pop_front());
        cnt = newf ? 1 : cnt + 1;
        newf = lst;
        done_exp = lst;
        hs_count++;
      end
      stall = ev && !m_tready;
      prev = {m_tdata_a, m_tlast_a};
      run = m_tvalid_a ? run + 1 : 0;
      if (run > max_run) max_run = run;
      if (s_tvalid && esr)
        for (int i = 0; i < 8; i++) begin
          q_a.push_back(s_tdata[7-i]);
          q_b.push_back(s_tdata[i]);
          q_l.push_back(s_tlast && i == 7);
        end
      rdy_ok = 1;
    end
  end

  task automatic send(input logic [7:0] d, input logic l);
    int k = 0;
    s_tvalid = 1; s_tdata = d; s_tlast = l;
    do begin @(negedge clk); k++; end while (!s_tready_a && k < 1000);
    if (k >= 1000) timeout("send");
    @(posedge clk); #1;
    s_tvalid = 0;
  endtask

  task automatic drain();
    int k = 0;
    do begin @(negedge clk); k++; end while (m_tvalid_a && k < 2000);
    if (k >= 2000) timeout("drain");
    @(negedge clk);
  endtask

  task automatic wait_bits(input int n);
    int t = hs_count + n;
    int k = 0;
    while (hs_count < t && k < 1000) begin @(negedge clk); #1; k++; end
    if (k >= 1000) timeout("wait_bits");
    @(posedge clk); #1;
  endtask

  initial begin
    int d0, base;
    logic [7:0] cap_a, cap_b;
    rst = 1; s_tvalid = 0; s_tdata = 0; s_tlast = 0;
    tbl[0] = '{8'hA5, 1'b1, 8'hA5, 8'hA5};
    tbl[1] = '{8'h01, 1'b0, 8'h01, 8'h80};
    tbl[2] = '{8'h80, 1'b1, 8'h80, 8'h01};
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1;
    hist_a.delete(); hist_b.delete(); max_run = 0; d0 = done_a_cnt;
    foreach (tbl[i]) send(tbl[i].data, tbl[i].last);
    drain();
    foreach (tbl[i]) begin
      for (int j = 0; j < 8; j++) begin
        cap_a = {cap_a[6:0], hist_a[8*i+j]};
        cap_b = {cap_b[6:0], hist_b[8*i+j]};
      end
      chk("tbl_seq_msb", cap_a, tbl[i].seq_a);
      chk("tbl_seq_lsb", cap_b, tbl[i].seq_b);
    end
    chk("tbl_no_bubble_run", max_run, 24);
    chk("tbl_frame_bits_a", frame_bits_a, 16);
    chk("tbl_frame_bits_b", frame_bits_b, 16);
    chk("tbl_frame_done_cnt", done_a_cnt - d0, 2);
    @(posedge clk); #1;
    send(8'h3C, 0);
    wait_bits(3);
    s_tvalid = 1; s_tdata = 8'hC3; s_tlast = 1;
    for (int k = 3; k < 8; k++) begin
      @(negedge clk);
      chk("mid_word_s_tready", s_tready_a, k == 7);
      @(posedge clk); #1;
    end
    s_tvalid = 0;
    drain();
    d0 = done_c_cnt;
    @(posedge clk); #1;
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 1);
    drain();
    chk("sat_frame_bits_c", frame_bits_c, 15);
    chk("sat_frame_bits_a", frame_bits_a, 24);
    chk("sat_frame_done_cnt", done_c_cnt - d0, 1);
    @(posedge clk); #1;
    send(8'hFF, 1);
    wait_bits(3);
    rst = 1;
    #1;
    chk("async_rst_m_tvalid", m_tvalid_a, 0);
    chk("async_rst_frame_bits", frame_bits_a, 0);
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1;
    send(8'h00, 1);
    drain();
    chk("post_rst_frame_bits", frame_bits_a, 8);
    base = hist_a.size();
    @(posedge clk); #1;
    rnd = 1;
    for (int w = 0; w < 100; w++) begin
      send(8'($urandom), $urandom_range(3) == 0);
      repeat ($urandom_range(2)) @(posedge clk);
      #1;
    end
    send(8'($urandom), 1);
    drain();
    rnd = 0;
    chk("rand_bit_count", hist_a.size() - base, 101 * 8);
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
